redmule_mx_slot_packer: RTL and testbench

REDMULE_MX_SLOT_PACKER -- requirements
Module: redmule_mx_slot_packer

---
 rtl/redmule_mx_slot_packer_if.sv | 12 +
 rtl/redmule_mx_slot_packer.sv | 159 +++++++++++++++
 tb/tb_redmule_mx_slot_packer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_mx_slot_packer_if.sv
// Valid/ready beat stream with byte strobes, used for the packed output beats.
interface redmule_mx_slot_packer_if #(
  parameter int unsigned DATAW = 512
);
  logic               valid;
  logic               ready;
  logic [DATAW-1:0]   data;
  logic [DATAW/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/redmule_mx_slot_packer.sv
// Packs pairs of MX slots into wide output beats, keeping each slot's shared
// exponent in a parallel FIFO. In FP16 mode every slot becomes its own
// half-populated beat. A flush emits a lone pending slot as a half beat.
module redmule_mx_slot_packer #(
  parameter int unsigned DATAW_ALIGN     = 512,
  parameter int unsigned MX_DATA_W       = 256,
  parameter int unsigned BEAT_FIFO_DEPTH = 2,
  parameter int unsigned EXP_FIFO_DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     mx_enable_i,
  input  logic                     slot_valid_i,
  output logic                     slot_ready_o,
  input  logic [MX_DATA_W-1:0]     slot_data_i,
  input  logic [7:0]               slot_exp_i,
  input  logic                     flush_i,
  redmule_mx_slot_packer_if.master z_data_o,
  output logic                     exp_valid_o,
  input  logic                     exp_ready_i,
  output logic [7:0]               exp_data_o,
  output logic                     idle_o
);

  localparam int unsigned STRBW      = DATAW_ALIGN / 8;
  localparam int unsigned HALF_STRBW = MX_DATA_W / 8;
  localparam int unsigned BPW        = (BEAT_FIFO_DEPTH > 1) ? $clog2(BEAT_FIFO_DEPTH) : 1;
  localparam int unsigned BCW        = $clog2(BEAT_FIFO_DEPTH + 1);
  localparam int unsigned EPW        = (EXP_FIFO_DEPTH > 1) ? $clog2(EXP_FIFO_DEPTH) : 1;
  localparam int unsigned ECW        = $clog2(EXP_FIFO_DEPTH + 1);

  localparam logic [BCW-1:0] BEAT_DEPTH = BCW'(BEAT_FIFO_DEPTH);
  localparam logic [BPW-1:0] BEAT_LAST  = BPW'(BEAT_FIFO_DEPTH - 1);
  localparam logic [ECW-1:0] EXP_DEPTH  = ECW'(EXP_FIFO_DEPTH);
  localparam logic [EPW-1:0] EXP_LAST   = EPW'(EXP_FIFO_DEPTH - 1);

  // Assembly state: lower slot held while waiting for its partner
  logic [MX_DATA_W-1:0] lo_q;
  logic                 half_q;
  logic                 flush_pend_q;

  // Beat FIFO
  logic [DATAW_ALIGN-1:0] beat_data_mem [BEAT_FIFO_DEPTH];
  logic [STRBW-1:0]       beat_strb_mem [BEAT_FIFO_DEPTH];
  logic [BPW-1:0]         beat_wr_ptr_q;
  logic [BPW-1:0]         beat_rd_ptr_q;
  logic [BCW-1:0]         beat_count_q;

  // Exponent FIFO
  logic [7:0]     exp_mem [EXP_FIFO_DEPTH];
  logic [EPW-1:0] exp_wr_ptr_q;
  logic [EPW-1:0] exp_rd_ptr_q;
  logic [ECW-1:0] exp_count_q;

  logic beat_space, exp_space, mx_ready;
  logic accept, mx_accept, fp_accept, flush_fire;
  logic beat_push, beat_pop, exp_push, exp_pop;
  logic beat_valid;
  logic [DATAW_ALIGN-1:0] push_data;
  logic [STRBW-1:0]       push_strb;

  function automatic logic [BPW-1:0] beat_ptr_inc(input logic [BPW-1:0] p);
    return (p == BEAT_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [EPW-1:0] exp_ptr_inc(input logic [EPW-1:0] p);
    return (p == EXP_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy and the mode select
  assign beat_space   = (beat_count_q < BEAT_DEPTH);
  assign exp_space    = (exp_count_q < EXP_DEPTH);
  assign mx_ready     = !flush_pend_q && exp_space && (!half_q || beat_space);
  assign slot_ready_o = mx_enable_i ? mx_ready : beat_space;

  assign accept     = slot_valid_i && slot_ready_o;
  assign mx_accept  = accept && mx_enable_i;
  assign fp_accept  = accept && !mx_enable_i;
  // A flush never competes with an accepted slot for the single push port
  assign flush_fire = flush_pend_q && half_q && beat_space && !accept;

  assign beat_valid = (beat_count_q != '0);
  assign beat_push  = (mx_accept && half_q) || fp_accept || flush_fire;
  assign beat_pop   = beat_valid && z_data_o.ready;
  assign exp_push   = mx_accept;
  assign exp_pop    = exp_valid_o && exp_ready_i;

  // Select the beat being written: full pair, FP16 slot, or flushed half
  always_comb begin
    push_data = '0;
    push_strb = '0;
    if (mx_accept && half_q) begin
      push_data = {slot_data_i, lo_q};
      push_strb = '1;
    end else if (fp_accept) begin
      push_data[MX_DATA_W-1:0]  = slot_data_i;
      push_strb[HALF_STRBW-1:0] = '1;
    end else if (flush_fire) begin
      push_data[MX_DATA_W-1:0]  = lo_q;
      push_strb[HALF_STRBW-1:0] = '1;
    end
  end

  // Storage: FIFO contents and the held lower slot are not reset
  always_ff @(posedge clk_i) begin
    if (beat_push) begin
      beat_data_mem[beat_wr_ptr_q] <= push_data;
      beat_strb_mem[beat_wr_ptr_q] <= push_strb;
    end
    if (exp_push) begin
      exp_mem[exp_wr_ptr_q] <= slot_exp_i;
    end
    if (mx_accept && !half_q) begin
      lo_q <= slot_data_i;
    end
  end

  // Control: pointers, counts, assembly flag and pending flush
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      beat_wr_ptr_q <= '0;
      beat_rd_ptr_q <= '0;
      beat_count_q  <= '0;
      exp_wr_ptr_q  <= '0;
      exp_rd_ptr_q  <= '0;
      exp_count_q   <= '0;
      half_q        <= 1'b0;
      flush_pend_q  <= 1'b0;
    end else begin
      if (beat_push) beat_wr_ptr_q <= beat_ptr_inc(beat_wr_ptr_q);
      if (beat_pop)  beat_rd_ptr_q <= beat_ptr_inc(beat_rd_ptr_q);
      if (beat_push && !beat_pop)      beat_count_q <= beat_count_q + 1'b1;
      else if (!beat_push && beat_pop) beat_count_q <= beat_count_q - 1'b1;

      if (exp_push) exp_wr_ptr_q <= exp_ptr_inc(exp_wr_ptr_q);
      if (exp_pop)  exp_rd_ptr_q <= exp_ptr_inc(exp_rd_ptr_q);
      if (exp_push && !exp_pop)      exp_count_q <= exp_count_q + 1'b1;
      else if (!exp_push && exp_pop) exp_count_q <= exp_count_q - 1'b1;

      if (mx_accept)       half_q <= !half_q;
      else if (flush_fire) half_q <= 1'b0;

      // A new request wins over retiring the current one
      if (flush_i)                                    flush_pend_q <= 1'b1;
      else if (flush_pend_q && (!half_q || flush_fire)) flush_pend_q <= 1'b0;
    end
  end

  assign z_data_o.valid = beat_valid;
  assign z_data_o.data  = beat_valid ? beat_data_mem[beat_rd_ptr_q] : '0;
  assign z_data_o.strb  = beat_valid ? beat_strb_mem[beat_rd_ptr_q] : '0;

  assign exp_valid_o = (exp_count_q != '0);
  assign exp_data_o  = exp_valid_o ? exp_mem[exp_rd_ptr_q] : 8'h00;

  assign idle_o = !half_q && !flush_pend_q && (beat_count_q == '0) && (exp_count_q == '0);

endmodule

// File: tb/tb_redmule_mx_slot_packer.sv
// Bench for redmule_mx_slot_packer: directed vector table, hand-written
// backpressure/flush/clear sequences, and random traffic against a queue model.
module tb_redmule_mx_slot_packer;

  localparam int DW = 512;
  localparam int MW = 256;
  localparam int BD = 2;
  localparam int ED = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, clear_i, mx_enable_i, slot_valid_i, slot_ready_o;
  logic [MW-1:0] slot_data_i;
  logic [7:0]    slot_exp_i, exp_data_o;
  logic          flush_i, exp_valid_o, exp_ready_i, idle_o;

  redmule_mx_slot_packer_if #(.DATAW(DW)) z_if ();

  redmule_mx_slot_packer #(
    .DATAW_ALIGN(DW), .MX_DATA_W(MW), .BEAT_FIFO_DEPTH(BD), .EXP_FIFO_DEPTH(ED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .mx_enable_i(mx_enable_i),
    .slot_valid_i(slot_valid_i), .slot_ready_o(slot_ready_o),
    .slot_data_i(slot_data_i), .slot_exp_i(slot_exp_i), .flush_i(flush_i),
    .z_data_o(z_if), .exp_valid_o(exp_valid_o), .exp_ready_i(exp_ready_i),
    .exp_data_o(exp_data_o), .idle_o(idle_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] STRB_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] STRB_LO  = 64'h0000_0000_FFFF_FFFF;

  // Reference model: contents of the beat and exponent FIFOs, pending slot, pending flush
  logic [511:0] m_beat_data [$];
  logic [63:0]  m_beat_strb [$];
  logic [7:0]   m_exp [$];
  bit           m_have_lo, m_fpend;
  logic [255:0] m_lo;
  int           m_pops;

  typedef struct {
    bit           mx, sv;
    logic [255:0] d;
    logic [7:0]   e;
    bit           zr, er;
    bit           x_ready, x_zvalid;
    logic [511:0] x_zdata;
    logic [63:0]  x_strb;
    bit           x_evalid;
    logic [7:0]   x_edata;
    bit           x_idle;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] ramp(input logic [7:0] base);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit mx, input bit sv, input logic [255:0] d, input logic [7:0] e,
                        input bit fl, input bit zr, input bit er);
    mx_enable_i  = mx;
    slot_valid_i = sv;
    slot_data_i  = d;
    slot_exp_i   = e;
    flush_i      = fl;
    z_if.ready   = zr;
    exp_ready_i  = er;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    m_beat_data.delete();
    m_beat_strb.delete();
    m_exp.delete();
    m_have_lo = 0;
    m_fpend   = 0;
    m_pops    = 0;
  endtask

  // Compare outputs against the model for the current cycle, then advance the model
  task automatic model_step();
    bit           bspace, m_ready, acc, ff, pre_lo;
    logic [511:0] xd;
    logic [63:0]  xs;
    logic [7:0]   xe;
    bspace  = m_beat_data.size() < BD;
    m_ready = mx_enable_i ? (!m_fpend && m_exp.size() < ED && (!m_have_lo || bspace)) : bspace;
    xd = (m_beat_data.size() != 0) ? m_beat_data[0] : '0;
    xs = (m_beat_strb.size() != 0) ? m_beat_strb[0] : '0;
    xe = (m_exp.size() != 0) ? m_exp[0] : 8'h00;
    chk("rnd_slot_ready", slot_ready_o, m_ready);
    chk("rnd_z_valid", z_if.valid, m_beat_data.size() != 0);
    chk("rnd_z_data", z_if.data, xd);
    chk("rnd_z_strb", z_if.strb, xs);
    chk("rnd_exp_valid", exp_valid_o, m_exp.size() != 0);
    chk("rnd_exp_data", exp_data_o, xe);
    chk("rnd_idle", idle_o, !m_have_lo && !m_fpend && m_beat_data.size() == 0 && m_exp.size() == 0);

    pre_lo = m_have_lo;
    acc    = slot_valid_i && m_ready;
    ff     = m_fpend && m_have_lo && bspace && !acc;

    if (m_beat_data.size() != 0 && z_if.ready) begin
      $display("beat %0d popped: strb=%h lo_word=%h", m_pops, m_beat_strb[0], m_beat_data[0][31:0]);
      void'(m_beat_data.pop_front());
      void'(m_beat_strb.pop_front());
      m_pops++;
    end
    if (m_exp.size() != 0 && exp_ready_i) void'(m_exp.pop_front());

    if (acc) begin
      if (mx_enable_i) begin
        m_exp.push_back(slot_exp_i);
        if (!m_have_lo) begin
          m_lo      = slot_data_i;
          m_have_lo = 1;
        end else begin
          m_beat_data.push_back({slot_data_i, m_lo});
          m_beat_strb.push_back(STRB_ALL);
          m_have_lo = 0;
        end
      end else begin
        m_beat_data.push_back({256'b0, slot_data_i});
        m_beat_strb.push_back(STRB_LO);
      end
    end
    if (ff) begin
      m_beat_data.push_back({256'b0, m_lo});
      m_beat_strb.push_back(STRB_LO);
      m_have_lo = 0;
    end
    if (flush_i)                     m_fpend = 1;
    else if (m_fpend && (!pre_lo || ff)) m_fpend = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] sa, sb, saa, s [6];
    logic [7:0]   e [6];
    logic [511:0] xb [3];
    int           acc, pops;
    bit           found;

    sa  = ramp(8'h01);
    sb  = ramp(8'h21);
    saa = {32{8'hAA}};
    for (int i = 0; i < 6; i++) begin
      s[i] = ramp(8'(i * 32 + 8'h41));
      e[i] = 8'(8'h40 + i);
    end

    tbl[0] = '{1, 1, sa, 8'h7F, 1, 1, 1, 0, '0, '0, 0, 8'h00, 1};
    tbl[1] = '{1, 1, sb, 8'h80, 1, 1, 1, 0, '0, '0, 1, 8'h7F, 0};
    tbl[2] = '{1, 0, '0, 8'h00, 1, 1, 1, 1, {sb, sa}, STRB_ALL, 1, 8'h80, 0};
    tbl[3] = '{0, 1, saa, 8'h00, 1, 1, 1, 0, '0, '0, 0, 8'h00, 1};
    tbl[4] = '{0, 0, '0, 8'h00, 1, 1, 1, 1, {256'b0, saa}, STRB_LO, 0, 8'h00, 0};
    tbl[5] = '{0, 0, '0, 8'h00, 1, 1, 1, 0, '0, '0, 0, 8'h00, 1};

    // Reset state
    do_reset();
    #1;
    chk("reset_slot_ready", slot_ready_o, 1'b1);
    chk("reset_z_valid", z_if.valid, 1'b0);
    chk("reset_z_data", z_if.data, '0);
    chk("reset_exp_valid", exp_valid_o, 1'b0);
    chk("reset_idle", idle_o, 1'b1);
    $display("reset: ready=%b zvalid=%b evalid=%b idle=%b", slot_ready_o, z_if.valid, exp_valid_o, idle_o);
    tick();

    // Directed vector table: MX pair packing then FP16 pass-through
    for (int v = 0; v < 6; v++) begin
      set_in(tbl[v].mx, tbl[v].sv, tbl[v].d, tbl[v].e, 1'b0, tbl[v].zr, tbl[v].er);
      #1;
      chk($sformatf("vec%0d_ready", v), slot_ready_o, tbl[v].x_ready);
      chk($sformatf("vec%0d_zvalid", v), z_if.valid, tbl[v].x_zvalid);
      chk($sformatf("vec%0d_zdata", v), z_if.data, tbl[v].x_zdata);
      chk($sformatf("vec%0d_zstrb", v), z_if.strb, tbl[v].x_strb);
      chk($sformatf("vec%0d_evalid", v), exp_valid_o, tbl[v].x_evalid);
      chk($sformatf("vec%0d_edata", v), exp_data_o, tbl[v].x_edata);
      chk($sformatf("vec%0d_idle", v), idle_o, tbl[v].x_idle);
      $display("vec %0d: ready=%b zvalid=%b evalid=%b edata=%h idle=%b",
               v, slot_ready_o, z_if.valid, exp_valid_o, exp_data_o, idle_o);
      tick();
    end

    // Beat backpressure: two beats fill the FIFO, one more slot parks in the assembly register
    do_reset();
    xb[0] = {s[1], s[0]};
    xb[1] = {s[3], s[2]};
    xb[2] = {s[5], s[4]};
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(1, acc < 6, s[acc < 6 ? acc : 0], e[acc < 6 ? acc : 0], 0, 0, 1);
      #1;
      if (slot_ready_o && acc < 6) acc++;
      tick();
    end
    chk("bp_accepted", acc, 5);
    set_in(1, 1, s[5], e[5], 0, 0, 1);
    #1;
    chk("bp_ready_low", slot_ready_o, 1'b0);
    chk("bp_z_valid", z_if.valid, 1'b1);
    chk("bp_head_stable", z_if.data, xb[0]);
    $display("backpressure: accepted=%0d ready=%b head_lo=%h", acc, slot_ready_o, z_if.data[31:0]);
    pops = 0;
    for (int c = 0; c < 30 && (pops < 3 || acc < 6); c++) begin
      set_in(1, acc < 6, s[acc < 6 ? acc : 0], e[acc < 6 ? acc : 0], 0, 1, 1);
      #1;
      if (z_if.valid && pops < 3) begin
        chk($sformatf("bp_beat%0d", pops), z_if.data, xb[pops]);
        $display("backpressure beat %0d lo_word=%h", pops, z_if.data[31:0]);
        pops++;
      end
      if (slot_ready_o && acc < 6) acc++;
      tick();
    end
    chk("bp_pops", pops, 3);
    chk("bp_all_accepted", acc, 6);

    // Exponent backpressure: the exponent FIFO alone throttles slots
    do_reset();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(1, acc < 6, s[acc < 6 ? acc : 0], e[acc < 6 ? acc : 0], 0, 1, 0);
      #1;
      if (slot_ready_o && acc < 6) acc++;
      tick();
    end
    chk("ebp_accepted", acc, 4);
    set_in(1, 1, s[4], e[4], 0, 1, 1);
    #1;
    chk("ebp_ready_low", slot_ready_o, 1'b0);
    chk("ebp_head", exp_data_o, e[0]);
    tick();
    for (int c = 0; c < 6; c++) begin
      set_in(1, acc < 6, s[acc < 6 ? acc : 0], e[acc < 6 ? acc : 0], 0, 1, 0);
      #1;
      if (slot_ready_o && acc < 6) acc++;
      tick();
    end
    chk("ebp_one_more", acc, 5);
    $display("exp backpressure: accepted=%0d", acc);

    // Flush of a lone slot
    do_reset();
    set_in(1, 1, sa, 8'h10, 0, 0, 0);
    #1;
    chk("flush_accept", slot_ready_o, 1'b1);
    tick();
    set_in(1, 0, '0, '0, 1, 0, 0);
    tick();
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      set_in(1, 0, '0, '0, 0, 0, 0);
      #1;
      if (z_if.valid) found = 1;
      else tick();
    end
    chk("flush_beat_seen", found, 1'b1);
    chk("flush_data", z_if.data, {256'b0, sa});
    chk("flush_strb", z_if.strb, STRB_LO);
    chk("flush_exp", exp_data_o, 8'h10);
    chk("flush_not_idle", idle_o, 1'b0);
    $display("flush: beat strb=%h exp=%h", z_if.strb, exp_data_o);
    tick();
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      set_in(1, 0, '0, '0, 0, 1, 1);
      #1;
      if (idle_o) found = 1;
      else tick();
    end
    chk("flush_idle_after_drain", found, 1'b1);
    tick();

    // Clear while holding half a beat
    do_reset();
    set_in(1, 1, sa, 8'h7F, 0, 0, 0);
    tick();
    set_in(1, 0, '0, '0, 0, 0, 0);
    clear_i = 1'b1;
    #1;
    chk("clear_busy_before", idle_o, 1'b0);
    tick();
    clear_i = 1'b0;
    #1;
    chk("clear_idle", idle_o, 1'b1);
    chk("clear_exp_valid", exp_valid_o, 1'b0);
    chk("clear_ready", slot_ready_o, 1'b1);
    $display("clear: idle=%b zvalid=%b evalid=%b", idle_o, z_if.valid, exp_valid_o);
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, '0, '0, 0, 1, 1);
      #1;
      chk($sformatf("clear_no_beat%0d", c), z_if.valid, 1'b0);
      tick();
    end

    // Random MX traffic, drain, then random FP16 traffic
    do_reset();
    for (int c = 0; c < 300; c++) begin
      set_in(1, $urandom_range(0, 9) < 7, rand256(), 8'($urandom), $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      #1;
      model_step();
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      set_in(1, 0, '0, '0, c == 0, 1, 1);
      #1;
      model_step();
      tick();
    end
    #1;
    chk("rnd_mx_drained", idle_o, 1'b1);
    for (int c = 0; c < 200; c++) begin
      set_in(0, $urandom_range(0, 9) < 7, rand256(), 8'($urandom), 0,
             $urandom_range(0, 9) < 6, $urandom_range(0, 1));
      #1;
      model_step();
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, '0, '0, 0, 1, 1);
      #1;
      model_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
